// File: rtl/logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit: op encoding and control bundle.
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

    // Per-beat control, captured together on accept.
    typedef struct packed {
        op_e  op;
        logic acc_en;
        logic acc_clr;
    } ctrl_t;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 16
);
    logic                           in_valid;
    logic                           in_ready;
    logic [logic_unit_pkg::OP_W-1:0] op;
    logic                           acc_en;
    logic                           acc_clr;
    logic [WIDTH-1:0]               a;
    logic [WIDTH-1:0]               b;
    logic                           out_valid;
    logic                           out_ready;
    logic [WIDTH-1:0]               out;
    logic                           out_any;
    logic                           out_zero;

    modport master (
        output in_valid, op, acc_en, acc_clr, a, b, out_ready,
        input  in_ready, out_valid, out, out_any, out_zero
    );

    modport slave (
        input  in_valid, op, acc_en, acc_clr, a, b, out_ready,
        output in_ready, out_valid, out, out_any, out_zero
    );
endinterface

// File: rtl/logic_op_w.sv
// Width-generic combinational bitwise operator; reusable outside the pipe.
module logic_op_w
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        case (op_e'(op))
            OP_AND:   res = x & y;
            OP_OR:    res = x | y;
            OP_XOR:   res = x ^ y;
            OP_NAND:  res = ~(x & y);
            OP_NOR:   res = ~(x | y);
            OP_XNOR:  res = ~(x ^ y);
            OP_NOTA:  res = ~x;
            OP_PASSB: res = y;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake, accumulator and
// reduction flags; one-cycle latency, full throughput.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    logic_unit_pipe_if.slave bus
);

    ctrl_t            ctl;
    logic             accept;
    logic             vld_q;
    logic             any_q;
    logic             zero_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] res;

    assign ctl      = '{op: op_e'(bus.op), acc_en: bus.acc_en, acc_clr: bus.acc_clr};
    assign accept   = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !vld_q || bus.out_ready;
    assign bus.out_valid = vld_q;
    assign bus.out       = out_q;
    assign bus.out_any   = any_q;
    assign bus.out_zero  = zero_q;

    // acc_clr on an accumulate beat starts the fold from ACC_RESET this beat.
    always_comb begin
        a_eff = bus.a;
        if (ctl.acc_en)
            a_eff = ctl.acc_clr ? ACC_RESET : acc;
    end

    logic_op_w #(.WIDTH(WIDTH)) u_op (
        .op  (ctl.op),
        .x   (a_eff),
        .y   (bus.b),
        .res (res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            out_q  <= '0;
            any_q  <= 1'b0;
            zero_q <= 1'b1;
            acc    <= ACC_RESET;
        end else if (accept) begin
            vld_q  <= 1'b1;
            out_q  <= res;
            any_q  <= |res;
            zero_q <= ~|res;
            if (ctl.acc_en)
                acc <= res;
            else if (ctl.acc_clr)
                acc <= ACC_RESET;
        end else if (vld_q && bus.out_ready) begin
            vld_q <= 1'b0;
        end
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the fixed 16-bit bitwise gate arrays.
- Applies one of eight bitwise operations to two WIDTH-bit operands.
- Registers the result behind a valid/ready handshake.
- Provides an accumulate mode that folds a stream of operands into an internal register; reduction flags (any-bit-set, zero) come with every result.
- Sits between operand sources (register file / bus) and consumers needing registered, back-pressurable logic results.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 1..64.
- ACC_RESET, 0, value loaded into the accumulator on rst and on acc_clr.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- op  input  3  operation select, sampled on accept.
- acc_en  input  1  accumulate mode for this beat, sampled on accept.
- acc_clr  input  1  clear accumulator before use for this beat, sampled on accept.
- a  input  WIDTH  operand A; ignored when acc_en=1.
- b  input  WIDTH  operand B.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer accepts the result this cycle.
- out  output  WIDTH  registered result.
- out_any  output  1  reduction OR of out; registered with out.
- out_zero  output  1  equals NOT out_any; registered with out.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out=0, out_any=0, out_zero=1.
  - Accumulator = ACC_RESET.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready; output transfer when out_valid && out_ready.
- Latency and throughput: one cycle from accept to out_valid=1. Full throughput of one beat per cycle while out_ready=1.
- Output register on accept: out, out_any and out_zero load the new result; out_valid=1.
- Output register on transfer without accept: out_valid=0; out and the flags hold their last value.
- Output stability: while out_valid=1 and out_ready=0, out, out_any and out_zero are stable and in_ready=0.
- Simultaneous transfer and accept in the same cycle: out_valid stays 1 and the new result replaces the old. No bubble, no loss.
- Operand selection:
  - A_eff = a when acc_en=0.
  - A_eff = ACC_RESET when acc_en=1 and acc_clr=1.
  - A_eff = accumulator when acc_en=1 and acc_clr=0.
- op codes:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 NOT A_eff (b ignored).
  - 7 PASS b (A_eff ignored).
- Accumulator update:
  - On accept with acc_en=1, the accumulator is set to the result.
  - On accept with acc_en=0 and acc_clr=1, the accumulator is set to ACC_RESET; result is a OP b.
  - The accumulator is otherwise unchanged, including during stalls.
- Back-to-back accumulate beats use the accumulator value updated by the previous accepted beat, with no hazard cycle.
- Unaccepted beats (in_valid=1, in_ready=0) have no effect on any state.
- Widths: all operations are strictly bitwise; no carries or sign extension. WIDTH=1 is legal, and then out_any equals out.
- Mid-operation reset: rst asserted at any time discards any pending result and the accumulator immediately (async). in_ready is 1 on the first cycle after release.
- X-safety: op, a and b are don't-care when in_valid=0 and must not propagate into state.

Decomposition:
- Shared package logic_unit_pkg:
  - op code constants OP_AND..OP_PASSB (3-bit).
  - OP_W=3.
- Sub-module logic_op_w:
  - Parameter WIDTH.
  - Purely combinational: (op, x, y) -> result.
  - Reusable by other datapath blocks.
- logic_unit_pipe holds the handshake, operand mux, accumulator, and output and flag registers.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-stall with out_valid=1 and accumulator=16'h00F0.
  - Required response: out_valid=0, out=0, out_zero=1 immediately; after release, an acc_en beat with op=OR, b=16'h0001 returns 16'h0001.
- Ops sweep (WIDTH=16):
  - Stimulus: a=16'hF0F0, b=16'hFF00, op 0..7.
  - Required response: outputs 16'hF000, FFF0, 0FF0, 0FFF, 000F, F00F, 0F0F, FF00 on consecutive cycles at full throughput, out_ready=1.
- Back-pressure:
  - Stimulus: out_ready=0 for 3 cycles after the first result, in_valid held high.
  - Required response: in_ready=0, out stable, no second beat accepted; on release, results appear in order with no drops or duplicates.
- Accumulate OR stream:
  - Stimulus: acc_clr=1 on the first beat, then b=16'h0001, 0x0100, 0x8000, op=OR, acc_en=1.
  - Required response: results 0001, 0101, 8101; a non-acc beat does not disturb the accumulator; the next acc beat OR 0 yields 8101.
- Flags:
  - Stimulus: op=AND with a=16'h00FF, b=16'hFF00.
  - Required response: out=0, out_any=0, out_zero=1; op=OR on the same operands gives out_any=1, out_zero=0.
- Parameter corners:
  - Stimulus: WIDTH=1 and WIDTH=64 builds with ACC_RESET all-ones, XOR accumulate of alternating patterns.
  - Required response: results match a reference model over 1000 random beats with random out_ready stalls.
